// File: rtl/fp32_pkg.sv
// fp32_pkg: binary32 field widths, constants, op encoding and operand unpacking
package fp32_pkg;
  localparam int EXP_W = 8;
  localparam int FRAC_W = 23;
  localparam int BIAS = 127;
  localparam logic [31:0] FP_QNAN = 32'h7FC00000;
  localparam logic [31:0] FP_PINF = 32'h7F800000;
  localparam logic [31:0] FP_ONE = 32'h3F800000;
  localparam logic [31:0] FP_HALF = 32'h3F000000;
  localparam logic [31:0] FP_1P5 = 32'h3FC00000;
  localparam logic OP_MUL = 1'b0;
  localparam logic OP_ADD = 1'b1;
  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W:0]   sig;
    logic              is_zero;
    logic              is_inf;
    logic              is_nan;
  } fp_unpacked_t;
  // Subnormal inputs collapse to signed zero with an all-zero significand.
  function automatic fp_unpacked_t fp_unpack(input logic [31:0] x);
    fp_unpacked_t u;
    u.sign = x[31];
    u.exp = x[30:23];
    u.is_zero = x[30:23] == '0;
    u.sig = u.is_zero ? '0 : {1'b1, x[22:0]};
    u.is_inf = &x[30:23] && x[22:0] == '0;
    u.is_nan = &x[30:23] && x[22:0] != '0;
    return u;
  endfunction
endpackage

// File: rtl/fp32_round_pack.sv
// fp32_round_pack: RNE rounding, range checks and packing of a normalised result
module fp32_round_pack
  import fp32_pkg::*;
(
  input  logic              sign_i,
  input  logic signed [9:0] exp_i,
  input  logic [23:0]       sig_i,
  input  logic              guard_i,
  input  logic              round_i,
  input  logic              sticky_i,
  output logic [31:0]       res_o
);
  logic              round_up;
  logic [24:0]       sum;
  logic signed [9:0] exp_r;
  logic [22:0]       frac_r;
  always_comb begin
    round_up = guard_i & (round_i | sticky_i | sig_i[0]);
    sum = {1'b0, sig_i} + 25'(round_up);
    exp_r = exp_i + 10'(sum[24]);
    frac_r = sum[24] ? sum[23:1] : sum[22:0];
    res_o = sig_i == '0 ? {sign_i, 31'b0}
          : exp_r >= 10'sd255 ? {sign_i, 8'hFF, 23'b0}
          : exp_r <= 10'sd0 ? {sign_i, 31'b0}
          : {sign_i, exp_r[EXP_W-1:0], frac_r};
  end
endmodule

// File: rtl/fp32_mul_add.sv
// fp32_mul_add: binary32 multiply or add selected per cycle, one-cycle registered result
module fp32_mul_add
  import fp32_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        op,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  output logic [31:0] out
);
  fp_unpacked_t      a, b;
  logic              mul_sign, mul_g, mul_r, mul_s;
  logic [47:0]       prod;
  logic signed [9:0] mul_exp;
  logic [23:0]       mul_sig;
  logic              mul_nan, mul_spec;
  logic [31:0]       mul_special;
  logic              swap, x_sign, y_sign;
  logic [7:0]        x_exp, diff;
  logic [23:0]       x_sig, y_sig;
  logic [49:0]       shifted;
  logic [26:0]       y_al, norm;
  logic [27:0]       sum;
  logic [4:0]        lz;
  logic signed [9:0] add_exp;
  logic [23:0]       add_sig;
  logic              add_g, add_r, add_s, add_sign;
  logic              add_nan, add_spec;
  logic [31:0]       add_special;
  logic              rp_sign, rp_g, rp_r, rp_s;
  logic signed [9:0] rp_exp;
  logic [23:0]       rp_sig;
  logic [31:0]       rp_res, out_d, out_q;
  always_comb begin
    a = fp_unpack(rs1);
    b = fp_unpack(rs2);
    mul_sign = a.sign ^ b.sign;
    prod = 48'(a.sig) * 48'(b.sig);
    mul_exp = 10'({2'b0, a.exp} + {2'b0, b.exp} - 10'(BIAS) + 10'(prod[47]));
    mul_sig = prod[47] ? prod[47:24] : prod[46:23];
    mul_g = prod[47] ? prod[23] : prod[22];
    mul_r = prod[47] ? prod[22] : prod[21];
    mul_s = prod[47] ? |prod[21:0] : |prod[20:0];
    mul_nan = a.is_nan | b.is_nan | (a.is_inf & b.is_zero) | (a.is_zero & b.is_inf);
    mul_spec = mul_nan | a.is_inf | b.is_inf | a.is_zero | b.is_zero;
    mul_special = mul_nan ? FP_QNAN
                : (a.is_inf | b.is_inf) ? {mul_sign, FP_PINF[30:0]}
                : {mul_sign, 31'b0};
  end
  // Add path: x is the larger magnitude; y is aligned keeping guard, round and sticky.
  always_comb begin
    swap = rs2[30:0] > rs1[30:0];
    x_sign = swap ? b.sign : a.sign;
    y_sign = swap ? a.sign : b.sign;
    x_exp = swap ? b.exp : a.exp;
    diff = swap ? b.exp - a.exp : a.exp - b.exp;
    x_sig = swap ? b.sig : a.sig;
    y_sig = swap ? a.sig : b.sig;
    shifted = {y_sig, 26'b0} >> diff;
    y_al = diff >= 8'd26 ? 27'd1 : {shifted[49:24], |shifted[23:0]};
    sum = x_sign == y_sign ? {1'b0, x_sig, 3'b0} + {1'b0, y_al}
                           : {1'b0, x_sig, 3'b0} - {1'b0, y_al};
    lz = '0;
    for (int i = 0; i < 27; i++)
      if (sum[i]) lz = 5'(26 - i);
    norm = sum[26:0] << lz;
    add_exp = sum[27] ? 10'({2'b0, x_exp} + 10'd1) : 10'({2'b0, x_exp} - 10'(lz));
    add_sig = sum[27] ? sum[27:4] : norm[26:3];
    add_g = sum[27] ? sum[3] : norm[2];
    add_r = sum[27] ? sum[2] : norm[1];
    add_s = sum[27] ? |sum[1:0] : norm[0];
    add_sign = sum == '0 ? 1'b0 : x_sign;
    add_nan = a.is_nan | b.is_nan | (a.is_inf & b.is_inf & (a.sign ^ b.sign));
    add_spec = add_nan | a.is_inf | b.is_inf | a.is_zero | b.is_zero;
    add_special = add_nan ? FP_QNAN
                : a.is_inf ? rs1
                : b.is_inf ? rs2
                : (a.is_zero & b.is_zero) ? {a.sign & b.sign, 31'b0}
                : a.is_zero ? rs2
                : rs1;
  end
  always_comb begin
    rp_sign = op == OP_ADD ? add_sign : mul_sign;
    rp_exp = op == OP_ADD ? add_exp : mul_exp;
    rp_sig = op == OP_ADD ? add_sig : mul_sig;
    rp_g = op == OP_ADD ? add_g : mul_g;
    rp_r = op == OP_ADD ? add_r : mul_r;
    rp_s = op == OP_ADD ? add_s : mul_s;
    out_d = op == OP_ADD ? (add_spec ? add_special : rp_res)
                         : (mul_spec ? mul_special : rp_res);
  end
  fp32_round_pack u_round_pack (
    .sign_i  (rp_sign),
    .exp_i   (rp_exp),
    .sig_i   (rp_sig),
    .guard_i (rp_g),
    .round_i (rp_r),
    .sticky_i(rp_s),
    .res_o   (rp_res)
  );
  always_ff @(posedge clk)
    out_q <= resetn ? '0 : out_d;
  assign out = out_q;
endmodule

// File: tb/tb_fp32_mul_add.sv
// tb_fp32_mul_add: scoreboard bench, directed vectors plus random ops against a real-arithmetic model
`timescale 1ns/1ps
module tb_fp32_mul_add;
  import fp32_pkg::*;
  logic        clk = 1'b0, resetn = 1'b1, op = 1'b0;
  logic [31:0] rs1 = '0, rs2 = '0, out;
  typedef struct {
    logic [31:0] want;
    time         t;
    string       name;
  } sb_t;
  sb_t sb[$];
  int vectors = 0, miscompares = 0;
  logic [31:0] specials[8] = '{32'h00000000, 32'h80000000, 32'h7F800000, 32'hFF800000,
                              32'h7FC00001, 32'h00400000, 32'h7F7FFFFF, 32'h00800000};

  always #5 clk = ~clk;

  fp32_mul_add dut (.clk(clk), .resetn(resetn), .op(op), .rs1(rs1), .rs2(rs2), .out(out));

  // binary32 -> double, with subnormals flushed to signed zero
  function automatic real to_real(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:23] == 8'h00) d = {f[31], 63'b0};
    else if (f[30:23] == 8'hFF) d = {f[31], 11'h7FF, f[22:0] != 23'b0, 51'b0};
    else d = {f[31], 11'(int'(f[30:23]) + 896), f[22:0], 29'b0};
    return $bitstoreal(d);
  endfunction

  // double -> binary32 with RNE, overflow to inf and flush of tiny results
  function automatic logic [31:0] to_fp32(input real r);
    logic [63:0] d;
    logic [52:0] m;
    logic [28:0] rem;
    logic [24:0] k;
    int e;
    d = $realtobits(r);
    if (d[62:52] == 11'h7FF) return d[51:0] != 52'b0 ? 32'h7FC00000 : {d[63], 8'hFF, 23'b0};
    if (d[62:52] == 11'h000) return {d[63], 31'b0};
    m = {1'b1, d[51:0]};
    rem = m[28:0];
    k = {1'b0, m[52:29]} + 25'((rem > 29'h10000000 || (rem == 29'h10000000 && m[29])) ? 1 : 0);
    e = int'(d[62:52]) - 896;
    if (k[24]) begin
      e++;
      k = k >> 1;
    end
    if (e >= 255) return {d[63], 8'hFF, 23'b0};
    if (e <= 0) return {d[63], 31'b0};
    return {d[63], 8'(e), k[22:0]};
  endfunction

  function automatic logic [31:0] model(input logic o, input logic [31:0] x, input logic [31:0] y);
    return to_fp32(o ? to_real(x) + to_real(y) : to_real(x) * to_real(y));
  endfunction

  function automatic logic [31:0] rnd_fp(input logic [31:0] near);
    logic [31:0] f;
    f = $urandom;
    case ($urandom_range(0, 9))
      0: f = specials[$urandom_range(0, 7)];
      1, 2: f[30:23] = 8'(int'(near[30:23]) + int'($urandom_range(0, 6)) - 3);
      3, 4, 5: f[30:23] = 8'($urandom_range(96, 160));
      6: f[30:23] = 8'(int'(near[30:23]) - int'($urandom_range(20, 30)));
      7: f = {~near[31], near[30:0] ^ ($urandom & 32'h000000FF)};
      default: ;
    endcase
    return f;
  endfunction

  task automatic apply(input logic r, input logic o, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] want, input string name);
    @(negedge clk);
    resetn = r;
    op = o;
    rs1 = x;
    rs2 = y;
    sb.push_back('{want: want, t: $time, name: name});
  endtask

  initial forever begin
    @(negedge clk);
    if (sb.size() > 0 && sb[0].t < $time) begin
      sb_t s;
      s = sb.pop_front();
      vectors++;
      if (out !== s.want) begin
        miscompares++;
        $display("FAIL %s: out=%h expected=%h", s.name, out, s.want);
      end
    end
  end

  initial begin
    logic [31:0] x, y;
    logic o;
    apply(1'b1, OP_MUL, 32'h40000000, 32'h40000000, 32'h00000000, "reset_0");
    apply(1'b1, OP_MUL, 32'h40000000, 32'h40000000, 32'h00000000, "reset_1");
    apply(1'b0, OP_MUL, 32'h40000000, 32'h40000000, 32'h40800000, "reset_release");
    apply(1'b0, OP_MUL, 32'h40000000, 32'h3F000000, 32'h3F800000, "mul_2x0.5");
    apply(1'b0, OP_MUL, 32'h3FC00000, 32'h3FC00000, 32'h40100000, "mul_1.5x1.5");
    apply(1'b0, OP_MUL, 32'hC0000000, 32'h3F000000, 32'hBF800000, "mul_neg");
    apply(1'b0, OP_MUL, 32'h7F7FFFFF, 32'h40000000, 32'h7F800000, "mul_overflow");
    apply(1'b0, OP_ADD, 32'h3FC00000, 32'hBF000000, 32'h3F800000, "add_sub");
    apply(1'b0, OP_ADD, 32'h3F800000, 32'h3F800000, 32'h40000000, "add_1+1");
    apply(1'b0, OP_ADD, 32'h40400000, 32'hC0400000, 32'h00000000, "add_cancel");
    apply(1'b0, OP_ADD, 32'h3F800000, 32'h3F000000, 32'h3FC00000, "add_1+0.5");
    apply(1'b0, OP_ADD, 32'h3F800000, 32'h33800000, 32'h3F800000, "rne_tie_down");
    apply(1'b0, OP_ADD, 32'h3F800000, 32'h33800001, 32'h3F800001, "rne_above_half");
    apply(1'b0, OP_ADD, 32'h3F800001, 32'h33800000, 32'h3F800002, "rne_tie_even");
    apply(1'b0, OP_MUL, 32'h7F800000, 32'h00000000, 32'h7FC00000, "mul_inf_x_0");
    apply(1'b0, OP_ADD, 32'h7F800000, 32'hFF800000, 32'h7FC00000, "add_inf_minus_inf");
    apply(1'b0, OP_ADD, 32'h7FC00001, 32'h3F800000, 32'h7FC00000, "add_nan_in");
    apply(1'b0, OP_MUL, 32'h00400000, 32'h3F800000, 32'h00000000, "mul_subnormal");
    apply(1'b0, OP_ADD, 32'h00000000, 32'h80000000, 32'h00000000, "add_p0_m0");
    apply(1'b0, OP_ADD, 32'h80000000, 32'h80000000, 32'h80000000, "add_m0_m0");
    for (int i = 0; i < 4; i++)
      apply(1'b0, i[0] ? OP_ADD : OP_MUL, 32'h40000000, 32'h40000000, 32'h40800000,
            $sformatf("interleave_%0d", i));
    apply(1'b0, OP_MUL, 32'h3FC00000, 32'h3FC00000, 32'h40100000, "pre_reset");
    apply(1'b1, OP_ADD, 32'h3F800000, 32'h3F800000, 32'h00000000, "mid_reset");
    apply(1'b0, OP_ADD, 32'h3F800000, 32'h3F800000, 32'h40000000, "post_reset");
    for (int i = 0; i < 4000; i++) begin
      x = rnd_fp($urandom);
      y = rnd_fp(x);
      o = 1'($urandom_range(0, 1));
      apply(1'b0, o, x, y, model(o, x, y), $sformatf("rand op=%0d a=%h b=%h", o, x, y));
    end
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      miscompares++;
      $display("FAIL drain: outstanding=%0d expected=0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
